// File: rtl/cpu_memory_pkg.sv
`default_nettype none
// =====================================================================
// CPU_Types : packet, access-width and FSM types for the memory stage
// Revision  : 1.0
// =====================================================================
package CPU_Types;

  localparam int XLEN = 32;
  localparam int REGW = 6;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_BAD  = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FAULT  = 2'd2
  } state_e;

  typedef struct packed {
    logic            strobe;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] value;
    logic            mem_read;
    logic            mem_write;
    logic            fence;
    width_e          width;
    logic            sgn;
    logic [XLEN-1:0] addr;
    logic [REGW-1:0] load_rd;
  } exec_pkt_t;

  typedef struct packed {
    logic            strobe;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] value;
  } wb_pkt_t;

  function automatic logic is_aligned(input width_e w, input logic [1:0] off);
    case (w)
      W_BYTE:  is_aligned = 1'b1;
      W_HALF:  is_aligned = ~off[0];
      W_WORD:  is_aligned = (off == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input width_e w, input logic [1:0] off);
    case (w)
      W_BYTE:  lane_mask = 4'b0001 << off;
      W_HALF:  lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate store data across lanes so the mask alone picks the bytes.
  function automatic logic [XLEN-1:0] lane_data(input width_e w, input logic [XLEN-1:0] d);
    case (w)
      W_BYTE:  lane_data = {4{d[7:0]}};
      W_HALF:  lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_memory_load_align.sv
`default_nettype none
// =====================================================================
// CPU_LoadAlign : selects the addressed lane of a read word and extends it
// Revision      : 1.0
// =====================================================================
module CPU_LoadAlign
  import CPU_Types::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  width_e      width_i,
  input  logic        signed_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
  // Halfwords only reach here when offset[0] is clear.
  assign half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    value_o = rdata_i;
    case (width_i)
      W_BYTE:  value_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      W_HALF:  value_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: value_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_memory.sv
`default_nettype none
// =====================================================================
// cpu_memory : memory stage - bus loads/stores, ALU pass-through, fences
// Revision   : 1.0
// =====================================================================
module cpu_memory
  import CPU_Types::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [82:0] i_data,
  output logic        o_busy,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [3:0]  o_bus_wmask,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic        o_fence,
  output logic        o_fault,
  output logic [38:0] o_data
);

  exec_pkt_t   pkt;
  state_e      state_q;
  logic        last_strobe_q;
  wb_pkt_t     data_q;
  logic        req_q;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [3:0]  wmask_q;
  logic [31:0] wdata_q;
  logic        fence_q;
  logic        fault_q;
  logic        new_pkt;
  logic        mem_op;
  logic [31:0] load_value;

  assign pkt     = exec_pkt_t'(i_data);
  assign new_pkt = (pkt.strobe != last_strobe_q);
  assign mem_op  = pkt.mem_read | pkt.mem_write;

  CPU_LoadAlign u_load_align (
    .rdata_i  (i_bus_rdata),
    .offset_i (pkt.addr[1:0]),
    .width_i  (pkt.width),
    .signed_i (pkt.sgn),
    .value_o  (load_value)
  );

  // A packet stays unconsumed through ACCESS; execute holds i_data while busy.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= S_IDLE;
      last_strobe_q <= 1'b0;
      data_q        <= '0;
      req_q         <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      wmask_q       <= '0;
      wdata_q       <= '0;
      fence_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      fence_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (new_pkt) begin
            if (!mem_op) begin
              data_q        <= '{strobe: ~data_q.strobe, rd: pkt.rd, value: pkt.value};
              last_strobe_q <= pkt.strobe;
              fence_q       <= pkt.fence;
            end else if (is_aligned(pkt.width, pkt.addr[1:0])) begin
              req_q   <= 1'b1;
              rw_q    <= pkt.mem_write;
              addr_q  <= {pkt.addr[31:2], 2'b00};
              wmask_q <= pkt.mem_write ? lane_mask(pkt.width, pkt.addr[1:0]) : 4'b0000;
              wdata_q <= lane_data(pkt.width, pkt.value);
              state_q <= S_ACCESS;
            end else begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end
          end
        end
        S_ACCESS: begin
          if (i_bus_ready) begin
            req_q         <= 1'b0;
            last_strobe_q <= pkt.strobe;
            state_q       <= S_IDLE;
            if (rw_q)
              data_q <= '{strobe: ~data_q.strobe, rd: '0, value: '0};
            else
              data_q <= '{strobe: ~data_q.strobe, rd: pkt.load_rd, value: load_value};
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy = ((state_q == S_ACCESS) && !i_bus_ready)
               || ((state_q == S_IDLE) && new_pkt && mem_op)
               || (state_q == S_FAULT);

  assign o_bus_request = req_q;
  assign o_bus_rw      = rw_q;
  assign o_bus_address = addr_q;
  assign o_bus_wmask   = wmask_q;
  assign o_bus_wdata   = wdata_q;
  assign o_fence       = fence_q;
  assign o_fault       = fault_q;
  assign o_data        = data_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory.sv
`default_nettype none
// =====================================================================
// tb_cpu_memory : scoreboard bench with a random bus slave for cpu_memory
// Revision      : 1.0
// =====================================================================
module tb_cpu_memory;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [82:0] i_data;
  logic [31:0] i_bus_rdata = 32'd0;
  logic        i_bus_ready = 1'b0;
  logic        o_busy, o_bus_request, o_bus_rw, o_fence, o_fault;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic [3:0]  o_bus_wmask;
  logic [38:0] o_data;

  always #5 clk = ~clk;

  cpu_memory dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_data        (i_data),
    .o_busy        (o_busy),
    .o_bus_request (o_bus_request),
    .o_bus_rw      (o_bus_rw),
    .o_bus_address (o_bus_address),
    .o_bus_wmask   (o_bus_wmask),
    .o_bus_wdata   (o_bus_wdata),
    .i_bus_rdata   (i_bus_rdata),
    .i_bus_ready   (i_bus_ready),
    .o_fence       (o_fence),
    .o_fault       (o_fault),
    .o_data        (o_data)
  );

  typedef struct {
    logic [38:0] data;
    logic        fence;
  } wb_exp_t;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  logic     cur_strobe = 1'b0;
  logic     hold_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] r, input int off,
                                             input logic [1:0] w, input logic sg);
    logic [31:0] x;
    if (w == 2'd2) return r;
    x = r >> (8 * off);
    if (w == 2'd0) begin
      x = x % 256;
      if (sg && x >= 128) x = x + 32'hFFFF_FF00;
    end else begin
      x = x % 65536;
      if (sg && x >= 32768) x = x + 32'hFFFF_0000;
    end
    return x;
  endfunction

  // Writeback monitor
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    wb_exp_t e;
    if (!i_reset) prev_strobe = 1'b0;
    else if (o_data[38] != prev_strobe) begin
      prev_strobe = o_data[38];
      if (wb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got 0x%0h, expected no writeback", o_data);
      end else begin
        e = wb_q.pop_front();
        chk("wb_data", o_data, e.data);
        chk("wb_fence", o_fence, e.fence);
      end
    end else begin
      chk("fence_idle", o_fence, 1'b0);
    end
  end

  // Bus slave: checks the request against the expectation and answers after a delay
  bus_exp_t    cur;
  bit          active = 0;
  int          wait_left, req_cycles;
  logic [68:0] held;
  always @(negedge clk) begin
    if (!i_reset) begin
      active      = 0;
      i_bus_ready = 1'b0;
    end else if (o_bus_request) begin
      if (hold_ready) i_bus_ready = 1'b0;
      else begin
        if (!active) begin
          active     = 1;
          req_cycles = 0;
          held       = {o_bus_rw, o_bus_address, o_bus_wmask, o_bus_wdata};
          if (bus_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_unexpected: got addr 0x%0h, expected no request", o_bus_address);
            cur = '{rw: o_bus_rw, addr: o_bus_address, mask: o_bus_wmask,
                    wdata: o_bus_wdata, rdata: 32'd0, delay: 0};
          end else begin
            cur = bus_q.pop_front();
            chk("bus_rw", o_bus_rw, cur.rw);
            chk("bus_addr", o_bus_address, cur.addr);
            if (cur.rw) begin
              chk("bus_wmask", o_bus_wmask, cur.mask);
              chk("bus_wdata", o_bus_wdata, cur.wdata);
            end
          end
          wait_left = cur.delay;
        end else begin
          chk("bus_stable", {o_bus_rw, o_bus_address, o_bus_wmask, o_bus_wdata}, held);
        end
        req_cycles++;
        if (wait_left == 0) begin
          i_bus_ready = 1'b1;
          i_bus_rdata = cur.rdata;
        end else begin
          wait_left--;
          i_bus_ready = 1'b0;
          i_bus_rdata = $urandom;
        end
      end
    end else begin
      if (active) begin
        chk("req_cycles", req_cycles, cur.delay + 1);
        active = 0;
      end
      i_bus_ready = 1'($urandom_range(0, 1));
      i_bus_rdata = $urandom;
    end
  end

  // Called at a negedge; returns at the negedge after the packet is consumed.
  task automatic send(input logic mr, input logic mw, input logic f, input logic [1:0] w,
                      input logic sg, input logic [5:0] rd, input logic [5:0] ld,
                      input logic [31:0] val, input logic [31:0] ad, input int delay,
                      input logic [31:0] rdata);
    logic     ns;
    bus_exp_t b;
    wb_exp_t  e;
    int       off, budget;
    bit       done;
    ns = ~cur_strobe;
    cur_strobe = ns;
    off = int'(ad[1:0]);
    if (!(mr || mw)) e = '{data: {ns, rd, val}, fence: f};
    else begin
      b.rw    = mw;
      b.addr  = ad & 32'hFFFF_FFFC;
      b.delay = delay;
      b.rdata = rdata;
      b.mask  = (w == 2'd0) ? 4'(1 << off) : (w == 2'd1) ? 4'(3 << off) : 4'hF;
      b.wdata = (w == 2'd0) ? val[7:0] * 32'h0101_0101
              : (w == 2'd1) ? val[15:0] * 32'h0001_0001 : val;
      bus_q.push_back(b);
      if (mw) e = '{data: {ns, 6'd0, 32'd0}, fence: 1'b0};
      else    e = '{data: {ns, ld, model_load(rdata, off, w, sg)}, fence: 1'b0};
    end
    wb_q.push_back(e);
    i_data = {ns, rd, val, mr, mw, f, w, sg, ad, ld};
    done = 0;
    budget = 40;
    while (!done && budget > 0) begin
      #1;
      if (!o_busy) done = 1;
      @(posedge clk);
      if (!done) begin
        @(negedge clk);
        budget--;
      end
    end
    if (!done) chk("handshake_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle so that only the asynchronous path can clear outputs.
  task automatic do_reset(input string tag);
    #2;
    i_reset = 1'b0;
    i_data  = '0;
    #1;
    chk({tag, "_data"}, o_data, 39'd0);
    chk({tag, "_req"}, o_bus_request, 1'b0);
    chk({tag, "_busout"}, {o_bus_rw, o_bus_address, o_bus_wmask, o_bus_wdata}, 69'd0);
    chk({tag, "_flags"}, {o_fence, o_fault, o_busy}, 3'b000);
    cur_strobe = 1'b0;
    wb_q.delete();
    bus_q.delete();
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic fault_case(input logic [31:0] ad, input logic [1:0] w, input string tag);
    cur_strobe = ~cur_strobe;
    i_data = {cur_strobe, 6'd4, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, w, 1'b0, ad, 6'd8};
    #1;
    chk({tag, "_busy0"}, o_busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_fault"}, o_fault, 1'b1);
    chk({tag, "_noreq"}, o_bus_request, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_busy_hold"}, {o_busy, o_fault, o_bus_request}, 3'b110);
    do_reset({tag, "_rst"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    logic [1:0]  w;
    logic [31:0] a;
    longint      t0, t1;

    i_reset = 1'b0;
    i_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_data", o_data, 39'd0);
    chk("rst_busout", {o_bus_request, o_bus_rw, o_bus_address, o_bus_wmask, o_bus_wdata}, 70'd0);
    chk("rst_flags", {o_fence, o_fault, o_busy}, 3'b000);
    i_reset = 1'b1;
    @(negedge clk);

    send(0, 0, 0, 2'd2, 0, 6'd5, 6'd0, 32'h0000_1234, 32'd0, 0, 32'd0);
    chk("alu_noreq", o_bus_request, 1'b0);
    chk("alu_value", o_data, {1'b1, 6'd5, 32'h0000_1234});
    send(0, 0, 1, 2'd0, 0, 6'd9, 6'd0, 32'hDEAD_BEEF, 32'd0, 0, 32'd0);

    send(1, 0, 0, 2'd0, 1, 6'd0, 6'd11, 32'd0, 32'h0000_0103, 2, 32'h80FF_FFFF);
    chk("lb_value", o_data[37:0], {6'd11, 32'hFFFF_FF80});

    send(0, 1, 0, 2'd1, 0, 6'd3, 6'd0, 32'h0000_ABCD, 32'h0000_0102, 1, 32'd0);
    chk("sh_wb", o_data[37:0], 38'd0);

    send(1, 0, 0, 2'd1, 0, 6'd0, 6'd12, 32'd0, 32'h0000_0202, 0, 32'h8001_7FFF);
    send(1, 0, 0, 2'd2, 0, 6'd0, 6'd13, 32'd0, 32'h0000_0300, 3, 32'hCAFE_F00D);

    t0 = $time;
    for (int i = 0; i < 5; i++)
      send(0, 0, 0, 2'd2, 0, 6'(i + 20), 6'd0, $urandom, 32'd0, 0, 32'd0);
    t1 = $time;
    chk("b2b_cycles", (t1 - t0) / 10, 5);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      w    = 2'($urandom_range(0, 2));
      a    = $urandom & ~((32'd1 << w) - 32'd1);
      if (kind < 2)
        send(0, 0, 1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), 6'($urandom),
             6'($urandom), $urandom, $urandom, 0, 32'd0);
      else if (kind == 2)
        send(1, 0, 0, w, 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), $urandom, a,
             $urandom_range(0, 3), $urandom);
      else
        send(0, 1, 0, w, 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), $urandom, a,
             $urandom_range(0, 3), 32'd0);
    end

    fault_case(32'h0000_0102, 2'd2, "lw_mis");
    fault_case(32'h0000_0101, 2'd1, "lh_mis");
    fault_case(32'h0000_0100, 2'd3, "w11");

    hold_ready = 1'b1;
    cur_strobe = ~cur_strobe;
    i_data = {cur_strobe, 6'd1, 32'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0200, 6'd7};
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_req_up", {o_bus_request, o_busy}, 2'b11);
    @(negedge clk);
    do_reset("mid_rst");
    hold_ready = 1'b0;
    send(0, 0, 0, 2'd2, 0, 6'd2, 6'd0, 32'h0BAD_F00D, 32'd0, 0, 32'd0);
    chk("post_rst_alu", o_data, {1'b1, 6'd2, 32'h0BAD_F00D});
    send(1, 0, 0, 2'd0, 0, 6'd0, 6'd17, 32'd0, 32'h0000_0401, 1, 32'h1234_5678);

    repeat (4) @(negedge clk);
    chk("wb_q_empty", wb_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
